// File: rtl/aqfp_tx_scheduler_if.sv
// Requester/channel bundle for the AQFP transmit scheduler.
// master = requester/channel side, slave = scheduler.
interface aqfp_tx_scheduler_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                tick;
    logic [NREQ-1:0]     req_valid;
    logic [2*NREQ-1:0]   req_val;
    logic [NREQ-1:0]     req_ready;
    logic [1:0]          tx_data;
    logic                tx_busy;
    logic [IDW-1:0]      grant_id;
    logic                missed_tick;
    logic                err;
    logic                err_clr;

    modport master (
        output tick, req_valid, req_val, err_clr,
        input  req_ready, tx_data, tx_busy, grant_id, missed_tick, err
    );

    modport slave (
        input  tick, req_valid, req_val, err_clr,
        output req_ready, tx_data, tx_busy, grant_id, missed_tick, err
    );
endinterface

// File: rtl/aqfp_tx_scheduler.sv
// Round-robin scheduler sharing one ioAQFP transmit channel; pulses start on ticks.
// Optional AQFP_TX_XCHECK_EN: sticky err on grant of a non-binary (qZ/qX) value.
module aqfp_tx_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned PW_CYC  = 3,
    parameter int unsigned GAP_CYC = 1
) (
    input logic               clk,
    input logic               rst_n,
    aqfp_tx_scheduler_if.slave bus
);
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned MAXC = (PW_CYC > GAP_CYC) ? PW_CYC : GAP_CYC;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam logic [1:0]  Q_Z  = 2'b00;
    localparam logic [1:0]  Q_X  = 2'b10;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t         state, state_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic [IDW-1:0] rr_ptr, rr_ptr_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [1:0]     tx_data_q, tx_data_d;
    logic           busy_q;
    logic           err_q, err_d;
    logic [IDW-1:0] winner;
    logic [1:0]     win_val;
    logic           found;
    logic           grant;
    logic           bad_val;

    // First pending requester at or above rr_ptr, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!found && bus.req_valid[IDW'((int'(rr_ptr) + k) % int'(NREQ))]) begin
                found  = 1'b1;
                winner = IDW'((int'(rr_ptr) + k) % int'(NREQ));
            end
        end
    end

    always_comb begin
        win_val = Q_Z;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (winner == IDW'(i)) win_val = bus.req_val[2*i +: 2];
        end
    end

    // rst_n gate keeps ready low while reset is held, even with tick and valid present.
    assign grant   = rst_n && (state == IDLE) && bus.tick && found;
    assign bad_val = ~win_val[0];

    assign bus.req_ready   = grant ? (NREQ'(1) << winner) : '0;
    assign bus.missed_tick = bus.tick && (state != IDLE);
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_busy     = busy_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.err         = err_q;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        rr_ptr_d   = rr_ptr;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        err_d      = err_q;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_d    = DRIVE;
                    cnt_d      = '0;
                    tx_data_d  = win_val[0] ? win_val : Q_X;
                    grant_id_d = winner;
                    rr_ptr_d   = IDW'((int'(winner) + 1) % int'(NREQ));
                end
            end
            DRIVE: begin
                if (cnt == CW'(PW_CYC - 1)) begin
                    cnt_d     = '0;
                    tx_data_d = Q_Z;
                    state_d   = (GAP_CYC > 0) ? GAP : IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AQFP_TX_XCHECK_EN
        // A new error wins over a simultaneous clear.
        if (bus.err_clr)      err_d = 1'b0;
        if (grant && bad_val) err_d = 1'b1;
`else
        err_d = 1'b0;
`endif
    end

`ifndef AQFP_TX_XCHECK_EN
    logic unused_xcheck;
    assign unused_xcheck = bus.err_clr ^ bad_val;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rr_ptr     <= '0;
            grant_id_q <= '0;
            tx_data_q  <= Q_Z;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            rr_ptr     <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= (state_d != IDLE);
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_aqfp_tx_scheduler.sv
// Bench for aqfp_tx_scheduler: default instance (4,3,1) plus a PW=1/GAP=0 instance.
module tb_aqfp_tx_scheduler;
    localparam int unsigned NREQ = 4;
    localparam int unsigned PW_A = 3;
`ifdef AQFP_TX_XCHECK_EN
    localparam logic XCHK = 1'b1;
`else
    localparam logic XCHK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    typedef struct {
        logic [1:0] id;
        logic [1:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mon_prev_busy = 1'b0;
    int   mon_run       = 0;

    aqfp_tx_scheduler_if #(.NREQ(NREQ)) bus_a ();
    aqfp_tx_scheduler_if #(.NREQ(NREQ)) bus_b ();

    aqfp_tx_scheduler #(.NREQ(NREQ), .PW_CYC(3), .GAP_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    aqfp_tx_scheduler #(.NREQ(NREQ), .PW_CYC(1), .GAP_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: pops expected grant at each pulse start, checks pulse length at its end.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev_busy = 1'b0;
            mon_run       = 0;
        end else begin
            if (bus_a.tx_busy && !mon_prev_busy) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_underflow: pulse id=%0d val=%b with no expected grant",
                             bus_a.grant_id, bus_a.tx_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus_a.grant_id !== mon_e.id || bus_a.tx_data !== mon_e.val) begin
                        miscompares++;
                        $display("FAIL sb_pulse: got id=%0d val=%b, expected id=%0d val=%b",
                                 bus_a.grant_id, bus_a.tx_data, mon_e.id, mon_e.val);
                    end
                end
            end
            if (bus_a.tx_busy && bus_a.tx_data != 2'b00) begin
                mon_run++;
            end else if (mon_run != 0) begin
                vectors++;
                if (mon_run != int'(PW_A)) begin
                    miscompares++;
                    $display("FAIL sb_pulse_len: got %0d cycles, expected %0d", mon_run, PW_A);
                end
                mon_run = 0;
            end
            mon_prev_busy = bus_a.tx_busy;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_a.tick = 1'b0; bus_a.req_valid = '0; bus_a.req_val = '0; bus_a.err_clr = 1'b0;
        bus_b.tick = 1'b0; bus_b.req_valid = '0; bus_b.req_val = '0; bus_b.err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus_a.tick = 1'b1;
        bus_a.req_valid = '1;
        bus_a.req_val = '1;
        @(negedge clk);
        vectors++;
        if (bus_a.req_ready !== 4'b0000) begin
            miscompares++; $display("FAIL rst_ready: got %b expected 0000", bus_a.req_ready);
        end
        vectors++;
        if (bus_a.tx_data !== 2'b00 || bus_a.tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_tx: got data=%b busy=%b expected 00/0", bus_a.tx_data, bus_a.tx_busy);
        end
        vectors++;
        if (bus_a.grant_id !== 2'd0 || bus_a.missed_tick !== 1'b0 || bus_a.err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_misc: got gid=%0d missed=%b err=%b expected 0/0/0",
                     bus_a.grant_id, bus_a.missed_tick, bus_a.err);
        end
        clear_inputs();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus_a.req_valid = 4'b0001;
        bus_a.req_val   = 8'b00_00_00_01;
        repeat (9) begin
            @(negedge clk);
            vectors++;
            if (bus_a.req_ready !== 4'b0000) begin
                miscompares++; $display("FAIL single_wait_ready: got %b expected 0000", bus_a.req_ready);
            end
            cyc();
        end
        bus_a.tick = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL single_ready: got %b expected 0001", bus_a.req_ready);
        end
        sb.push_back('{2'd0, 2'b01});
        cyc();
        bus_a.tick = 1'b0;
        bus_a.req_valid = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            vectors++;
            if (bus_a.tx_data !== ((c <= 3) ? 2'b01 : 2'b00) || bus_a.tx_busy !== (c <= 4)
                || bus_a.grant_id !== 2'd0) begin
                miscompares++;
                $display("FAIL single_seq c=%0d: got data=%b busy=%b gid=%0d", c,
                         bus_a.tx_data, bus_a.tx_busy, bus_a.grant_id);
            end
            cyc();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus_a.req_valid = 4'b1111;
        bus_a.req_val   = {2'b01, 2'b11, 2'b01, 2'b11};
        cyc();
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % 4;
            bus_a.tick = 1'b1;
            @(negedge clk);
            vectors++;
            if (bus_a.req_ready !== 4'(1 << e) || bus_a.missed_tick !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_grant g=%0d: got ready=%b missed=%b expected ready index %0d",
                         g, bus_a.req_ready, bus_a.missed_tick, e);
            end
            sb.push_back('{2'(e), (e % 2 == 0) ? 2'b11 : 2'b01});
            cyc();
            bus_a.tick = 1'b0;
            repeat (5) cyc();
        end
        bus_a.req_valid = '0;
        repeat (2) cyc();
    endtask

    task automatic test_dropped_tick();
        do_reset();
        bus_a.req_valid = 4'b0011;
        bus_a.req_val   = 8'b00_00_01_11;
        repeat (3) cyc();
        bus_a.tick = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL drop_first: got %b expected 0001", bus_a.req_ready);
        end
        sb.push_back('{2'd0, 2'b11});
        cyc();
        bus_a.tick = 1'b0;
        bus_a.req_valid = 4'b0010;
        cyc();
        bus_a.tick = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.missed_tick !== 1'b1 || bus_a.req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL drop_drive: got missed=%b ready=%b expected 1/0000",
                     bus_a.missed_tick, bus_a.req_ready);
        end
        cyc();
        bus_a.tick = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus_a.missed_tick !== 1'b0) begin
            miscompares++; $display("FAIL drop_pulse_width: got missed=%b expected 0", bus_a.missed_tick);
        end
        cyc();
        bus_a.tick = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.missed_tick !== 1'b1 || bus_a.req_ready !== 4'b0000 || bus_a.tx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_last_gap: got missed=%b ready=%b busy=%b expected 1/0000/1",
                     bus_a.missed_tick, bus_a.req_ready, bus_a.tx_busy);
        end
        cyc();
        @(negedge clk);
        vectors++;
        if (bus_a.missed_tick !== 1'b0 || bus_a.req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL drop_first_idle: got missed=%b ready=%b expected 0/0010",
                     bus_a.missed_tick, bus_a.req_ready);
        end
        sb.push_back('{2'd1, 2'b01});
        cyc();
        bus_a.tick = 1'b0;
        bus_a.req_valid = '0;
        repeat (6) cyc();
    endtask

    task automatic test_coercion();
        do_reset();
        bus_a.req_valid = 4'b0100;
        bus_a.req_val   = 8'b00_00_00_00;
        cyc();
        bus_a.tick = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.req_ready !== 4'b0100) begin
            miscompares++; $display("FAIL coerce_ready: got %b expected 0100", bus_a.req_ready);
        end
        sb.push_back('{2'd2, 2'b10});
        cyc();
        bus_a.tick = 1'b0;
        bus_a.req_valid = '0;
        @(negedge clk);
        vectors++;
        if (bus_a.tx_data !== 2'b10 || bus_a.grant_id !== 2'd2 || bus_a.err !== XCHK) begin
            miscompares++;
            $display("FAIL coerce_t1: got data=%b gid=%0d err=%b expected 10/2/%b",
                     bus_a.tx_data, bus_a.grant_id, bus_a.err, XCHK);
        end
        cyc();
        bus_a.err_clr = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.tx_data !== 2'b10 || bus_a.err !== XCHK) begin
            miscompares++;
            $display("FAIL coerce_t2: got data=%b err=%b expected 10/%b", bus_a.tx_data, bus_a.err, XCHK);
        end
        cyc();
        bus_a.err_clr = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus_a.tx_data !== 2'b10 || bus_a.err !== 1'b0) begin
            miscompares++;
            $display("FAIL coerce_t3: got data=%b err=%b expected 10/0", bus_a.tx_data, bus_a.err);
        end
        cyc();
        cyc();
        // qX grant with a simultaneous clear: set must win
        bus_a.req_valid = 4'b0001;
        bus_a.req_val   = 8'b00_00_00_10;
        bus_a.tick      = 1'b1;
        bus_a.err_clr   = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL coerce_wrap_ready: got %b expected 0001", bus_a.req_ready);
        end
        sb.push_back('{2'd0, 2'b10});
        cyc();
        bus_a.tick = 1'b0;
        bus_a.err_clr = 1'b0;
        bus_a.req_valid = '0;
        @(negedge clk);
        vectors++;
        if (bus_a.err !== XCHK || bus_a.tx_data !== 2'b10) begin
            miscompares++;
            $display("FAIL coerce_set_wins: got err=%b data=%b expected %b/10", bus_a.err, bus_a.tx_data, XCHK);
        end
        repeat (6) cyc();
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus_a.req_valid = 4'b1010;
        bus_a.req_val   = 8'b11_00_01_00;
        cyc();
        bus_a.tick = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL midrst_first: got %b expected 0010", bus_a.req_ready);
        end
        sb.push_back('{2'd1, 2'b01});
        cyc();
        bus_a.tick = 1'b0;
        cyc();
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus_a.tx_data !== 2'b00 || bus_a.tx_busy !== 1'b0 || bus_a.grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL midrst_async: got data=%b busy=%b gid=%0d expected 00/0/0",
                     bus_a.tx_data, bus_a.tx_busy, bus_a.grant_id);
        end
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.tx_data !== 2'b00 || bus_a.tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_release: got data=%b busy=%b expected 00/0", bus_a.tx_data, bus_a.tx_busy);
        end
        cyc();
        bus_a.tick = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL midrst_rr: got %b expected 0010", bus_a.req_ready);
        end
        sb.push_back('{2'd1, 2'b01});
        cyc();
        bus_a.tick = 1'b0;
        bus_a.req_valid = '0;
        repeat (6) cyc();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus_b.req_valid = 4'b1010;
        bus_b.req_val   = 8'b01_00_11_00;
        cyc();
        for (int g = 0; g < 4; g++) begin
            int e;
            e = (g % 2 == 0) ? 1 : 3;
            bus_b.tick = 1'b1;
            @(negedge clk);
            vectors++;
            if (bus_b.req_ready !== 4'(1 << e) || bus_b.missed_tick !== 1'b0
                || bus_b.tx_data !== 2'b00 || bus_b.tx_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_grant g=%0d: got ready=%b missed=%b data=%b busy=%b expected index %0d",
                         g, bus_b.req_ready, bus_b.missed_tick, bus_b.tx_data, bus_b.tx_busy, e);
            end
            cyc();
            bus_b.tick = 1'b0;
            @(negedge clk);
            vectors++;
            if (bus_b.tx_data !== ((e == 1) ? 2'b11 : 2'b01) || bus_b.tx_busy !== 1'b1
                || bus_b.grant_id !== 2'(e) || bus_b.missed_tick !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_pulse g=%0d: got data=%b busy=%b gid=%0d missed=%b",
                         g, bus_b.tx_data, bus_b.tx_busy, bus_b.grant_id, bus_b.missed_tick);
            end
            cyc();
        end
        bus_b.req_valid = '0;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_dropped_tick();
        test_coercion();
        test_mid_reset();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d pending grants expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
